fht_but_pipe: RTL and testbench

Parametrised, valid-qualified radix-2 Hartley butterfly: the next-generation core for the FHT stage datapath. It computes Y0 = (X0 + X1·COS + X2·SIN)·2^-SCALE and Y1 = (X0 − X1·COS − X2·SIN)·2^-SCALE. It adds a runtime-selectable rounding mode, output saturation with overflow flags, and a multiplier-bypass mode for stage 0. A fixed two-cycle pipeline is driven by a per-sample valid bit, so stage controllers can issue bubbles without tracking latency.

---
 rtl/fht_but_pipe_if.sv | 48 ++++
 rtl/fht_but_pipe.sv | 147 ++++++++++++++
 tb/tb_fht_but_pipe.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fht_but_pipe_if.sv
// ---------------------------------------------------------------------------
// fht_but_pipe_if
// Bus bundle for the radix-2 Hartley butterfly pipeline.
//
// Handshake: valid-only, no ready. A sample is taken on every rising clock
// edge where iVALID=1, and the consumer must accept it. Each output sample
// is marked by a one-cycle oVALID pulse, and the data lines hold their last
// value while oVALID=0.
//
// Signals
//   iVALID, iBYPASS, iRND[1:0]     sample qualifier and per-sample modes
//   iX_0, iX_1, iX_2 [D_BIT]       signed data
//   iSIN, iCOS [W_BIT]             signed twiddles, unity = 2^(W_BIT-2)
//   iCLR_OVF                       clears the sticky overflow flag
//   oVALID, oY_0, oY_1             registered results
//   oOVF_0, oOVF_1, oOVF_STKY      per-sample and sticky saturation flags
// Modports: master drives the i* lines, slave (the butterfly) drives the o* lines.
// ---------------------------------------------------------------------------
interface fht_but_pipe_if #(
   parameter int D_BIT = 17,
   parameter int W_BIT = 12
);
   logic                    iVALID;
   logic                    iBYPASS;
   logic [1:0]              iRND;
   logic signed [D_BIT-1:0] iX_0;
   logic signed [D_BIT-1:0] iX_1;
   logic signed [D_BIT-1:0] iX_2;
   logic signed [W_BIT-1:0] iSIN;
   logic signed [W_BIT-1:0] iCOS;
   logic                    iCLR_OVF;
   logic                    oVALID;
   logic signed [D_BIT-1:0] oY_0;
   logic signed [D_BIT-1:0] oY_1;
   logic                    oOVF_0;
   logic                    oOVF_1;
   logic                    oOVF_STKY;

   modport master (
      output iVALID, iBYPASS, iRND, iX_0, iX_1, iX_2, iSIN, iCOS, iCLR_OVF,
      input  oVALID, oY_0, oY_1, oOVF_0, oOVF_1, oOVF_STKY
   );

   modport slave (
      input  iVALID, iBYPASS, iRND, iX_0, iX_1, iX_2, iSIN, iCOS, iCLR_OVF,
      output oVALID, oY_0, oY_1, oOVF_0, oOVF_1, oOVF_STKY
   );
endinterface

// File: rtl/fht_but_pipe.sv
// ---------------------------------------------------------------------------
// fht_but_pipe
// Two-stage, valid-qualified radix-2 Hartley butterfly:
//   Y0 = (X0 + X1*COS + X2*SIN) * 2^-SCALE
//   Y1 = (X0 - X1*COS - X2*SIN) * 2^-SCALE
// The butterfly supports per-sample rounding mode, saturation with
// overflow flags, and a multiplier bypass (product = X1 * unity).
//
// Ports
//   iCLK    rising-edge clock
//   iRESET  asynchronous active-low reset, clears every register
//   bus     fht_but_pipe_if.slave (data, modes, results, flags)
// Parameters
//   D_BIT  data width, W_BIT twiddle width, SCALE result right shift (0/1)
//
// Stage 1 forms the full-precision product sum P. Stage 2 forms A +/- P,
// then rounds, shifts and saturates, and registers the result on the
// outputs. Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module fht_but_pipe #(
   parameter int D_BIT = 17,
   parameter int W_BIT = 12,
   parameter int SCALE = 1
) (
   input  logic          iCLK,
   input  logic          iRESET,
   fht_but_pipe_if.slave bus
);

   localparam int U  = W_BIT - 2;          // log2 of twiddle unity
   localparam int F  = U + SCALE;          // total fractional shift
   localparam int PW = D_BIT + W_BIT + 1;  // product-sum width
   localparam int SW = PW + 1;             // sum/difference width, cannot wrap
   localparam int RW = SW + 1;             // headroom so the rounding add cannot wrap

   localparam logic signed [RW-1:0] ONE   = RW'(1);
   localparam logic signed [RW-1:0] HALF  = ONE <<< (F - 1);
   localparam logic signed [RW-1:0] Y_MAX = (ONE <<< (D_BIT - 1)) - ONE;
   localparam logic signed [RW-1:0] Y_MIN = -(ONE <<< (D_BIT - 1));

   // Round v by 2^F in the selected mode, then clamp it to D_BIT.
   // The result is returned as {overflow, value}.
   function automatic logic [D_BIT:0] round_sat(input logic signed [SW-1:0] v,
                                                input logic [1:0]           mode);
      logic signed [RW-1:0] add;
      logic signed [RW-1:0] vr;
      logic signed [RW-1:0] sh;
      logic [D_BIT:0]       res;
      case (mode)
         2'b00:   add = '0;
         // Bias of half-1 plus bit F breaks exact ties toward an even quotient.
         2'b10:   add = HALF - ONE + (v[F] ? ONE : '0);
         // A negative tie loses one LSB of bias, so the floor moves away from zero.
         default: add = v[SW-1] ? (HALF - ONE) : HALF;
      endcase
      vr = RW'(v) + add;
      sh = vr >>> F;
      if (sh > Y_MAX) begin
         res = {1'b1, Y_MAX[D_BIT-1:0]};
      end else if (sh < Y_MIN) begin
         res = {1'b1, Y_MIN[D_BIT-1:0]};
      end else begin
         res = {1'b0, sh[D_BIT-1:0]};
      end
      return res;
   endfunction

   // ---------------- stage 1: product sum ----------------
   logic signed [PW-1:0]    x1_e, x2_e, cos_e, sin_e;
   logic signed [PW-1:0]    p_d, p_q;
   logic signed [D_BIT-1:0] x0_q;
   logic [1:0]              rnd_q;
   logic                    v1_q;

   always_comb begin
      x1_e  = PW'(bus.iX_1);
      x2_e  = PW'(bus.iX_2);
      cos_e = PW'(bus.iCOS);
      sin_e = PW'(bus.iSIN);
      if (bus.iBYPASS) begin
         p_d = x1_e <<< U;
      end else begin
         p_d = x1_e * cos_e + x2_e * sin_e;
      end
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         v1_q  <= 1'b0;
         p_q   <= '0;
         x0_q  <= '0;
         rnd_q <= '0;
      end else begin
         v1_q <= bus.iVALID;
         if (bus.iVALID) begin
            p_q   <= p_d;
            x0_q  <= bus.iX_0;
            rnd_q <= bus.iRND;
         end
      end
   end

   // ---------------- stage 2: add/sub, round, saturate ----------------
   logic signed [SW-1:0]    a_w, s_w, d_w;
   logic signed [D_BIT-1:0] y0_d, y1_d, y0_q, y1_q;
   logic                    ovf0_d, ovf1_d, ovf0_q, ovf1_q;
   logic                    stky_d, stky_q;
   logic                    v2_q;

   always_comb begin
      a_w = SW'(x0_q) <<< U;
      s_w = a_w + SW'(p_q);
      d_w = a_w - SW'(p_q);
      {ovf0_d, y0_d} = round_sat(s_w, rnd_q);
      {ovf1_d, y1_d} = round_sat(d_w, rnd_q);
      // A new overflow wins over a clear in the same cycle.
      stky_d = (bus.iCLR_OVF ? 1'b0 : stky_q) | (v1_q & (ovf0_d | ovf1_d));
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         v2_q   <= 1'b0;
         y0_q   <= '0;
         y1_q   <= '0;
         ovf0_q <= 1'b0;
         ovf1_q <= 1'b0;
         stky_q <= 1'b0;
      end else begin
         v2_q   <= v1_q;
         stky_q <= stky_d;
         if (v1_q) begin
            y0_q   <= y0_d;
            y1_q   <= y1_d;
            ovf0_q <= ovf0_d;
            ovf1_q <= ovf1_d;
         end
      end
   end

   assign bus.oVALID    = v2_q;
   assign bus.oY_0      = y0_q;
   assign bus.oY_1      = y1_q;
   assign bus.oOVF_0    = ovf0_q;
   assign bus.oOVF_1    = ovf1_q;
   assign bus.oOVF_STKY = stky_q;

endmodule

// File: tb/tb_fht_but_pipe.sv
// ---------------------------------------------------------------------------
// tb_fht_but_pipe
// Two butterflies (SCALE=1 and SCALE=0) share one stimulus stream. A
// reference model works out each sample with plain integer arithmetic.
// A per-DUT expected queue is compared against the outputs every cycle.
// ---------------------------------------------------------------------------
module tb_fht_but_pipe;

   localparam int D_BIT = 17;
   localparam int W_BIT = 12;
   localparam int EW    = 2 * D_BIT + 2;   // {y0, y1, ovf0, ovf1}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fht_but_pipe_if #(.D_BIT(D_BIT), .W_BIT(W_BIT)) bus_s1 ();
   fht_but_pipe_if #(.D_BIT(D_BIT), .W_BIT(W_BIT)) bus_s0 ();

   fht_but_pipe #(.D_BIT(D_BIT), .W_BIT(W_BIT), .SCALE(1)) dut_s1 (
      .iCLK   (clk),
      .iRESET (rst_n),
      .bus    (bus_s1)
   );

   fht_but_pipe #(.D_BIT(D_BIT), .W_BIT(W_BIT), .SCALE(0)) dut_s0 (
      .iCLK   (clk),
      .iRESET (rst_n),
      .bus    (bus_s0)
   );

   // The SCALE=0 instance gets the same inputs.
   assign bus_s0.iVALID   = bus_s1.iVALID;
   assign bus_s0.iBYPASS  = bus_s1.iBYPASS;
   assign bus_s0.iRND     = bus_s1.iRND;
   assign bus_s0.iX_0     = bus_s1.iX_0;
   assign bus_s0.iX_1     = bus_s1.iX_1;
   assign bus_s0.iX_2     = bus_s1.iX_2;
   assign bus_s0.iSIN     = bus_s1.iSIN;
   assign bus_s0.iCOS     = bus_s1.iCOS;
   assign bus_s0.iCLR_OVF = bus_s1.iCLR_OVF;

   // ---------------- scoreboard state ----------------
   int            total = 0;
   int            bad   = 0;
   logic [EW-1:0] exp_q[2][$];    // index = SCALE of the instance
   logic [EW-1:0] last_w[2];
   bit            stky_m[2];
   bit            v_hist[$];
   bit            clr_m;

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Divide by 2^f with the selected rounding rule.
   function automatic longint rnd_div(input longint v, input int f, input bit [1:0] mode);
      longint m, h, q, r;
      m = longint'(1) << f;
      h = m / 2;
      q = v >>> f;           // floor
      r = v - q * m;         // 0 <= r < m
      case (mode)
         2'b00: return q;
         2'b10: begin
            if (r > h) return q + 1;
            if (r == h) return q + (q & 1);
            return q;
         end
         default: begin      // nearest, ties away from zero
            if (r > h) return q + 1;
            if (r == h && v >= 0) return q + 1;
            return q;
         end
      endcase
   endfunction

   function automatic logic [EW-1:0] model(input longint x0, input longint x1,
                                           input longint x2, input longint cs,
                                           input longint sn, input bit byp,
                                           input bit [1:0] mode, input int scale);
      longint unity, lim, p, a, y[2];
      bit     o[2];
      logic [D_BIT-1:0] yb[2];
      unity = longint'(1) << (W_BIT - 2);
      lim   = longint'(1) << (D_BIT - 1);
      p     = byp ? x1 * unity : x1 * cs + x2 * sn;
      a     = x0 * unity;
      y[0]  = rnd_div(a + p, W_BIT - 2 + scale, mode);
      y[1]  = rnd_div(a - p, W_BIT - 2 + scale, mode);
      for (int k = 0; k < 2; k++) begin
         o[k] = 1'b0;
         if (y[k] > lim - 1) begin y[k] = lim - 1; o[k] = 1'b1; end
         if (y[k] < -lim)    begin y[k] = -lim;    o[k] = 1'b1; end
         yb[k] = y[k][D_BIT-1:0];
      end
      return {yb[0], yb[1], o[0], o[1]};
   endfunction

   // ---------------- DUT observation ----------------
   function automatic logic [EW-1:0] got_w(input int idx);
      if (idx == 1) return {bus_s1.oY_0, bus_s1.oY_1, bus_s1.oOVF_0, bus_s1.oOVF_1};
      return {bus_s0.oY_0, bus_s0.oY_1, bus_s0.oOVF_0, bus_s0.oOVF_1};
   endfunction

   function automatic bit got_v(input int idx);
      return (idx == 1) ? bus_s1.oVALID : bus_s0.oVALID;
   endfunction

   function automatic bit got_s(input int idx);
      return (idx == 1) ? bus_s1.oOVF_STKY : bus_s0.oOVF_STKY;
   endfunction

   task automatic observe(input bit exp_v);
      logic [EW-1:0] w;
      for (int idx = 0; idx < 2; idx++) begin
         check($sformatf("valid_s%0d", idx), longint'(got_v(idx)), longint'(exp_v));
         if (exp_v) begin
            w = exp_q[idx].pop_front();
            check($sformatf("data_s%0d", idx), longint'(got_w(idx)), longint'(w));
            last_w[idx] = w;
            stky_m[idx] = (clr_m ? 1'b0 : stky_m[idx]) | w[1] | w[0];
         end else begin
            check($sformatf("hold_s%0d", idx), longint'(got_w(idx)), longint'(last_w[idx]));
            stky_m[idx] = clr_m ? 1'b0 : stky_m[idx];
         end
         check($sformatf("stky_s%0d", idx), longint'(got_s(idx)), longint'(stky_m[idx]));
      end
   endtask

   task automatic check_zero(input string tag);
      for (int idx = 0; idx < 2; idx++) begin
         check($sformatf("%s_valid_s%0d", tag, idx), longint'(got_v(idx)), 0);
         check($sformatf("%s_data_s%0d", tag, idx), longint'(got_w(idx)), 0);
         check($sformatf("%s_stky_s%0d", tag, idx), longint'(got_s(idx)), 0);
      end
   endtask

   task automatic model_reset();
      for (int idx = 0; idx < 2; idx++) begin
         exp_q[idx].delete();
         last_w[idx] = '0;
         stky_m[idx] = 1'b0;
      end
      v_hist.delete();
   endtask

   // ---------------- driver ----------------
   // One clock cycle: drive on the falling edge, check 1 ns after the rising edge.
   task automatic drive(input bit v, input bit byp, input bit [1:0] rnd,
                        input longint x0, input longint x1, input longint x2,
                        input longint cs, input longint sn, input bit clr);
      bit ev;
      @(negedge clk);
      bus_s1.iVALID   = v;
      bus_s1.iBYPASS  = byp;
      bus_s1.iRND     = rnd;
      bus_s1.iX_0     = x0[D_BIT-1:0];
      bus_s1.iX_1     = x1[D_BIT-1:0];
      bus_s1.iX_2     = x2[D_BIT-1:0];
      bus_s1.iCOS     = cs[W_BIT-1:0];
      bus_s1.iSIN     = sn[W_BIT-1:0];
      bus_s1.iCLR_OVF = clr;
      clr_m = clr;
      if (v) begin
         for (int s = 0; s < 2; s++) exp_q[s].push_back(model(x0, x1, x2, cs, sn, byp, rnd, s));
      end
      v_hist.push_back(v);
      @(posedge clk);
      #1;
      // The output after this edge belongs to the sample driven one cycle earlier.
      ev = (v_hist.size() >= 2) ? v_hist[v_hist.size() - 2] : 1'b0;
      while (v_hist.size() > 2) void'(v_hist.pop_front());
      observe(ev);
   endtask

   task automatic idle(input bit clr);
      drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0, clr);
   endtask

   function automatic longint rand_x();
      logic signed [D_BIT-1:0] t;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) return (longint'(1) << (D_BIT - 1)) - 1;
      if (sel == 1) return -(longint'(1) << (D_BIT - 1));
      t = D_BIT'($urandom());
      return longint'(t);
   endfunction

   function automatic longint rand_w();
      logic signed [W_BIT-1:0] t;
      int sel;
      sel = $urandom_range(0, 5);
      if (sel == 0) return 1024;
      if (sel == 1) return -1024;
      t = W_BIT'($urandom());
      return longint'(t);
   endfunction

   // ---------------- stimulus ----------------
   int  rnd_tab[3][3];
   int  rnd_x0[3];
   bit  pat[5];

   initial begin
      rnd_x0  = '{1, -1, 3};
      rnd_tab = '{'{0, -1, 1}, '{1, -1, 2}, '{0, 0, 2}};
      pat     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      clr_m   = 1'b0;
      model_reset();

      rst_n           = 1'b0;
      bus_s1.iVALID   = 1'b0;
      bus_s1.iBYPASS  = 1'b0;
      bus_s1.iRND     = 2'b00;
      bus_s1.iX_0     = '0;
      bus_s1.iX_1     = '0;
      bus_s1.iX_2     = '0;
      bus_s1.iSIN     = '0;
      bus_s1.iCOS     = '0;
      bus_s1.iCLR_OVF = 1'b0;
      #1;
      check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b0);

      // Basic butterfly: 100 +/- 50, halved.
      drive(1'b1, 1'b0, 2'b01, 100, 50, 0, 1024, 0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      check("basic_y0", bus_s1.oY_0, 75);
      check("basic_y1", bus_s1.oY_1, 25);
      check("basic_ovf", longint'({bus_s1.oOVF_0, bus_s1.oOVF_1}), 0);

      // Rounding modes on half-LSB inputs.
      for (int m = 0; m < 3; m++) begin
         for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'(m), rnd_x0[i], 0, 0, 1024, 0, 1'b0);
            idle(1'b0);
            check($sformatf("rnd%0d_x%0d_y0", m, rnd_x0[i]), bus_s1.oY_0, rnd_tab[m][i]);
            check($sformatf("rnd%0d_x%0d_y1", m, rnd_x0[i]), bus_s1.oY_1, bus_s1.oY_0);
         end
      end

      // Saturation and sticky flag on the SCALE=0 instance.
      drive(1'b1, 1'b0, 2'b01, 65535, 65535, 0, 1024, 0, 1'b0);
      idle(1'b0);
      check("sat_y0", bus_s0.oY_0, 65535);
      check("sat_ovf0", longint'(bus_s0.oOVF_0), 1);
      check("sat_y1", bus_s0.oY_1, 0);
      check("sat_ovf1", longint'(bus_s0.oOVF_1), 0);
      check("sat_stky", longint'(bus_s0.oOVF_STKY), 1);
      idle(1'b1);
      check("clr_stky", longint'(bus_s0.oOVF_STKY), 0);
      drive(1'b1, 1'b0, 2'b01, 65535, 65535, 0, 1024, 0, 1'b0);
      idle(1'b1);
      check("clr_vs_ovf_stky", longint'(bus_s0.oOVF_STKY), 1);
      idle(1'b1);

      // Bypass ignores X2/SIN/COS.
      drive(1'b1, 1'b1, 2'b01, 10, 4, rand_x(), rand_w(), rand_w(), 1'b0);
      idle(1'b0);
      check("byp_y0", bus_s1.oY_0, 7);
      check("byp_y1", bus_s1.oY_1, 3);

      // Valid pattern with the rounding mode toggling every sample.
      for (int k = 0; k < 5; k++) begin
         drive(pat[k], 1'b0, (k % 2) ? 2'b10 : 2'b01, 200 + 37 * k, rand_x(), rand_x(),
               rand_w(), rand_w(), 1'b0);
      end
      idle(1'b0);
      idle(1'b0);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
               rand_x(), rand_x(), rand_x(), rand_w(), rand_w(), $urandom_range(0, 19) == 0);
      end
      idle(1'b0);
      idle(1'b0);

      // Reset with samples in flight: outputs drop at once, nothing stale returns.
      drive(1'b1, 1'b0, 2'b01, 1234, 500, -300, 700, 900, 1'b0);
      drive(1'b1, 1'b0, 2'b10, -4321, -77, 66, -512, 300, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      model_reset();
      @(negedge clk);
      bus_s1.iVALID = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) idle(1'b0);
      drive(1'b1, 1'b0, 2'b01, 100, 50, 0, 1024, 0, 1'b0);
      idle(1'b0);
      check("post_rst_y0", bus_s1.oY_0, 75);
      idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
